// File: rtl/icache_fetch_resp_pkg.sv
// Shared definitions for the icache fetch responder: FSM encoding, line geometry,
// slot-mask table and the latched fetch-group record.
package icache_fetch_resp_pkg;

  localparam int FG_ADDR_W     = 32;
  localparam int LINE_OFFSET_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  // Valid slots from the entry word onwards, matching the fetch stage's next-PC step.
  localparam logic [3:0] SLOT_MASK_TBL [4] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};

  typedef struct packed {
    logic [FG_ADDR_W-1:0] pc;
    logic                 delot;
  } fetch_group_t;

  function automatic logic [3:0] slot_mask(input logic [1:0] slot, input logic delot);
    logic [3:0] m;
    if (delot) begin
      m = 4'b0001 << slot;
    end else begin
      m = SLOT_MASK_TBL[slot];
    end
    return m;
  endfunction

endpackage

// File: rtl/icache_linebuf.sv
// One-entry line buffer: remembers the last filled line (tag + data) and reports a
// hit for a matching lookup tag. Only cleared by reset.
module icache_linebuf #(
  parameter int TAG_W  = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              fill_en_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] data_q;

  // Entry storage, overwritten by each accepted line fill.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_en_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
    end else begin
      valid_q <= valid_q;
      tag_q   <= tag_q;
      data_q  <= data_q;
    end
  end

  assign hit_o  = valid_q & (tag_q == lookup_tag_i);
  assign data_o = data_q;

endmodule

// File: rtl/icache_fetch_resp.sv
// Responder end of the IF->icache fetch interface: one line fetch at a time, returned
// to decode with a slot mask. Define ICACHE_LINEBUF_EN to add a one-entry line buffer.
module icache_fetch_resp
  import icache_fetch_resp_pkg::*;
#(
  parameter int ADDR_W = FG_ADDR_W,
  parameter int INSN_W = 32
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                if_valid_ns,
  input  logic [ADDR_W-1:0]   if_icache_pc,
  input  logic                if_rw,
  input  logic [3:0]          if_rwen,
  input  logic                if_icache_delot_en,
  output logic                icache_allin,
  input  logic                ex_bp_error,
  input  logic                exc_flush_all,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [4*INSN_W-1:0] mem_rdata,
  output logic                icache_id_valid,
  output logic [ADDR_W-1:0]   icache_id_pc,
  output logic [4*INSN_W-1:0] icache_id_insn,
  output logic [3:0]          icache_id_mask,
  output logic                icache_id_delot_en,
  input  logic                id_allin
);

  localparam int LINE_W = 4 * INSN_W;
  localparam int TAG_W  = ADDR_W - LINE_OFFSET_W;

  logic [1:0]        state_q, state_d;
  logic              kill_q, kill_d;
  fetch_group_t      req_q, req_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              id_valid_q, id_valid_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [LINE_W-1:0] id_insn_q, id_insn_d;
  logic [3:0]        id_mask_q, id_mask_d;
  logic              id_delot_q, id_delot_d;

  logic              flush_s;
  logic              allin_s;
  logic              accept_s;
  logic              lb_hit_s;
  logic [LINE_W-1:0] lb_data_s;
  logic              unused_rwen_s;

  assign flush_s       = ex_bp_error | exc_flush_all;
  assign allin_s       = (state_q == ST_IDLE) | ((state_q == ST_OUT) & id_allin);
  assign accept_s      = if_valid_ns & ~if_rw & allin_s & ~flush_s;
  assign unused_rwen_s = ^if_rwen;

`ifdef ICACHE_LINEBUF_EN
  logic fill_en_s;

  assign fill_en_s = (state_q == ST_WAIT) & mem_rvalid & ~kill_q & ~flush_s;

  icache_linebuf #(
    .TAG_W  (TAG_W),
    .DATA_W (LINE_W)
  ) u_linebuf (
    .clk          (clk),
    .rst_         (rst_),
    .fill_en_i    (fill_en_s),
    .fill_tag_i   (req_q.pc[ADDR_W-1:LINE_OFFSET_W]),
    .fill_data_i  (mem_rdata),
    .lookup_tag_i (if_icache_pc[ADDR_W-1:LINE_OFFSET_W]),
    .hit_o        (lb_hit_s),
    .data_o       (lb_data_s)
  );
`else
  assign lb_hit_s  = 1'b0;
  assign lb_data_s = '0;
`endif

  // Next-state logic for the fetch FSM, memory request and decode-side group.
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    req_d      = req_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_insn_d  = id_insn_q;
    id_mask_d  = id_mask_q;
    id_delot_d = id_delot_q;

    case (state_q)
      ST_IDLE, ST_OUT: begin
        if (accept_s) begin
          req_d.pc    = if_icache_pc;
          req_d.delot = if_icache_delot_en;
          if (lb_hit_s) begin
            state_d    = ST_OUT;
            id_valid_d = 1'b1;
            id_pc_d    = if_icache_pc;
            id_insn_d  = lb_data_s;
            id_mask_d  = slot_mask(if_icache_pc[3:2], if_icache_delot_en);
            id_delot_d = if_icache_delot_en;
          end else begin
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = {if_icache_pc[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
            id_valid_d = 1'b0;
          end
        end else if ((state_q == ST_OUT) && (flush_s || id_allin)) begin
          // Flush takes priority over a decode handshake; either way the group retires.
          state_d    = ST_IDLE;
          id_valid_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end

      ST_REQ: begin
        if (flush_s) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
        if (mem_gnt) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
        end else begin
          mem_req_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (mem_rvalid) begin
          if (kill_q || flush_s) begin
            kill_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_OUT;
            id_valid_d = 1'b1;
            id_pc_d    = req_q.pc;
            id_insn_d  = mem_rdata;
            id_mask_d  = slot_mask(req_q.pc[3:2], req_q.delot);
            id_delot_d = req_q.delot;
          end
        end else if (flush_s) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        kill_d     = 1'b0;
        mem_req_d  = 1'b0;
        id_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= ST_IDLE;
      kill_q     <= 1'b0;
      req_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_insn_q  <= '0;
      id_mask_q  <= 4'b0000;
      id_delot_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      req_q      <= req_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_insn_q  <= id_insn_d;
      id_mask_q  <= id_mask_d;
      id_delot_q <= id_delot_d;
    end
  end

  assign icache_allin       = allin_s;
  assign mem_req            = mem_req_q;
  assign mem_addr           = mem_addr_q;
  assign icache_id_valid    = id_valid_q;
  assign icache_id_pc       = id_pc_q;
  assign icache_id_insn     = id_insn_q;
  assign icache_id_mask     = id_mask_q;
  assign icache_id_delot_en = id_delot_q;

endmodule

// File: tb/tb_icache_fetch_resp.sv
// Directed bench for icache_fetch_resp: table of single fetches plus hand-written
// sequences for backpressure, flushes, reset and the optional line buffer.
module tb_icache_fetch_resp;

  logic         clk = 1'b0;
  logic         rst_ = 1'b0;
  logic         if_valid_ns = 1'b0;
  logic [31:0]  if_icache_pc = 32'h0;
  logic         if_rw = 1'b0;
  logic [3:0]   if_rwen = 4'h0;
  logic         if_icache_delot_en = 1'b0;
  logic         icache_allin;
  logic         ex_bp_error = 1'b0;
  logic         exc_flush_all = 1'b0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [127:0] mem_rdata = 128'h0;
  logic         icache_id_valid;
  logic [31:0]  icache_id_pc;
  logic [127:0] icache_id_insn;
  logic [3:0]   icache_id_mask;
  logic         icache_id_delot_en;
  logic         id_allin = 1'b1;

  int tests = 0;
  int failed = 0;

  icache_fetch_resp dut (
    .clk                (clk),
    .rst_               (rst_),
    .if_valid_ns        (if_valid_ns),
    .if_icache_pc       (if_icache_pc),
    .if_rw              (if_rw),
    .if_rwen            (if_rwen),
    .if_icache_delot_en (if_icache_delot_en),
    .icache_allin       (icache_allin),
    .ex_bp_error        (ex_bp_error),
    .exc_flush_all      (exc_flush_all),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_gnt            (mem_gnt),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata),
    .icache_id_valid    (icache_id_valid),
    .icache_id_pc       (icache_id_pc),
    .icache_id_insn     (icache_id_insn),
    .icache_id_mask     (icache_id_mask),
    .icache_id_delot_en (icache_id_delot_en),
    .id_allin           (id_allin)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0]  pc;
    logic         delot;
    logic [127:0] data;
    logic [3:0]   exp_mask;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Minimum-latency fetch: accept at T, gnt at T+1, rvalid at T+2, group at T+3.
  task automatic fetch_min(input logic [31:0] pc, input logic delot,
                           input logic [127:0] data, input logic [3:0] exp_mask);
    logic [31:0] line;
    line = {pc[31:4], 4'b0000};
    if_valid_ns = 1'b1; if_icache_pc = pc; if_icache_delot_en = delot;
    #1 check("allin_idle", icache_allin, 1'b1);
    step();
    if_valid_ns = 1'b0; if_icache_delot_en = 1'b0;
    check("mem_req_t1", mem_req, 1'b1);
    check("mem_addr", mem_addr, line);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("mem_req_dropped", mem_req, 1'b0);
    check("valid_t2", icache_id_valid, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = data;
    step();
    mem_rvalid = 1'b0;
    check("valid_t3", icache_id_valid, 1'b1);
    check("id_pc", icache_id_pc, pc);
    check("id_insn", icache_id_insn, data);
    check("id_mask", icache_id_mask, exp_mask);
    check("id_delot", icache_id_delot_en, delot);
    step();
    check("valid_after_hs", icache_id_valid, 1'b0);
  endtask

  initial begin
    vecs[0] = '{32'hBFC00000, 1'b0, 128'h44444444_33333333_22222222_11111111, 4'b1111};
    vecs[1] = '{32'hBFC00018, 1'b0, 128'h88888888_77777777_66666666_55555555, 4'b1100};
    vecs[2] = '{32'hBFC0002C, 1'b0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 4'b1000};
    vecs[3] = '{32'hBFC00034, 1'b1, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 4'b0010};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", icache_id_valid, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_id_pc", icache_id_pc, 32'h0);
    check("rst_id_insn", icache_id_insn, 128'h0);
    check("rst_id_mask", icache_id_mask, 4'h0);
    check("rst_id_delot", icache_id_delot_en, 1'b0);
    rst_ = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      fetch_min(vecs[i].pc, vecs[i].delot, vecs[i].data, vecs[i].exp_mask);
    end

    // Write request and stray rvalid in IDLE are both ignored
    if_valid_ns = 1'b1; if_rw = 1'b1; if_icache_pc = 32'h00000700;
    mem_rvalid = 1'b1; mem_rdata = 128'hDEAD;
    step();
    if_valid_ns = 1'b0; if_rw = 1'b0; mem_rvalid = 1'b0;
    check("rw_ignored_req", mem_req, 1'b0);
    check("stray_rvalid", icache_id_valid, 1'b0);

    // Backpressure: hold OUT for 5 cycles, then back-to-back accept
    if_valid_ns = 1'b1; if_icache_pc = 32'h00001004;
    step();
    if_valid_ns = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 128'hA5A5; id_allin = 1'b0;
    step();
    mem_rvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", icache_id_valid, 1'b1);
      check("bp_pc", icache_id_pc, 32'h00001004);
      check("bp_insn", icache_id_insn, 128'hA5A5);
      check("bp_mask", icache_id_mask, 4'b1110);
      check("bp_allin", icache_allin, 1'b0);
      step();
    end
    id_allin = 1'b1; if_valid_ns = 1'b1; if_icache_pc = 32'h00002000;
    #1 check("bp_allin_rise", icache_allin, 1'b1);
    step();
    if_valid_ns = 1'b0;
    check("b2b_mem_req", mem_req, 1'b1);
    check("b2b_mem_addr", mem_addr, 32'h00002000);
    check("b2b_valid_drop", icache_id_valid, 1'b0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 128'h2222;
    step();
    mem_rvalid = 1'b0;
    check("b2b_valid", icache_id_valid, 1'b1);
    check("b2b_pc", icache_id_pc, 32'h00002000);
    step();

    // Flush while waiting: data arriving 3 cycles later is dropped
    if_valid_ns = 1'b1; if_icache_pc = 32'h00003000;
    step();
    if_valid_ns = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; ex_bp_error = 1'b1;
    step();
    ex_bp_error = 1'b0;
    step();
    check("fw_valid_a", icache_id_valid, 1'b0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 128'hBAD0;
    step();
    mem_rvalid = 1'b0;
    check("fw_valid_b", icache_id_valid, 1'b0);
    check("fw_idle_allin", icache_allin, 1'b1);
    fetch_min(32'h00004008, 1'b0, 128'h4444, 4'b1100);

    // Flush in REQ: mem_req held until gnt, response dropped
    if_valid_ns = 1'b1; if_icache_pc = 32'h00005000;
    step();
    if_valid_ns = 1'b0; exc_flush_all = 1'b1;
    check("fr_req_a", mem_req, 1'b1);
    step();
    exc_flush_all = 1'b0;
    check("fr_req_b", mem_req, 1'b1);
    step();
    check("fr_req_c", mem_req, 1'b1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("fr_req_gnt", mem_req, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 128'hBAD1;
    step();
    mem_rvalid = 1'b0;
    check("fr_valid", icache_id_valid, 1'b0);
    check("fr_idle", icache_allin, 1'b1);

    // Flush coinciding with a request in IDLE: not accepted
    if_valid_ns = 1'b1; if_icache_pc = 32'h00006000; ex_bp_error = 1'b1;
    step();
    if_valid_ns = 1'b0; ex_bp_error = 1'b0;
    check("fc_no_req", mem_req, 1'b0);
    step();
    check("fc_no_req2", mem_req, 1'b0);

    // Asynchronous reset mid-transaction
    if_valid_ns = 1'b1; if_icache_pc = 32'h00007000;
    step();
    if_valid_ns = 1'b0;
    check("ar_req", mem_req, 1'b1);
    #2 rst_ = 1'b0;
    #1 check("ar_req_cleared", mem_req, 1'b0);
    check("ar_addr_cleared", mem_addr, 32'h0);
    check("ar_idle", icache_allin, 1'b1);
    step();
    rst_ = 1'b1;
    step();

    // Line buffer: 0x100 then 0x108 in the same line
    fetch_min(32'h00000100, 1'b0, 128'hCAFE, 4'b1111);
    if_valid_ns = 1'b1; if_icache_pc = 32'h00000108;
    step();
    if_valid_ns = 1'b0;
`ifdef ICACHE_LINEBUF_EN
    check("lb_no_req", mem_req, 1'b0);
    check("lb_valid", icache_id_valid, 1'b1);
    check("lb_mask", icache_id_mask, 4'b1100);
    check("lb_insn", icache_id_insn, 128'hCAFE);
    step();
`else
    check("nolb_req", mem_req, 1'b1);
    check("nolb_valid", icache_id_valid, 1'b0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 128'hCAFE;
    step();
    mem_rvalid = 1'b0;
    check("nolb_valid_late", icache_id_valid, 1'b1);
    check("nolb_mask", icache_id_mask, 4'b1100);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/icache_fetch_resp.md
Name: icache_fetch_resp

Overview:
- Responder end of the IF→icache fetch interface. Accepts one fetch-group request per handshake (PC, delay-slot flag) from the fetch stage.
- Fetches the 16-byte aligned line from the memory/bus port and returns the 4 instruction words plus a valid-slot mask to the decode stage.
- Drives the `icache_allin` backpressure the fetch stage stalls on, and discards in-flight fetches on pipeline flush.

Parameters:
- ADDR_W, 32, address width.
- INSN_W, 32, instruction width; a line is 4×INSN_W.

Ports:
- clk  in  1  clock
- rst_  in  1  reset; one clock, asynchronous active-low reset
- if_valid_ns  in  1  fetch request valid
- if_icache_pc  in  ADDR_W  request PC
- if_rw  in  1  must be 0 (read); 1 is ignored as a request
- if_rwen  in  4  byte enables; ignored for reads, retained for interface compatibility
- if_icache_delot_en  in  1  request is a lone delay-slot fetch
- icache_allin  out  1  request accept-ready
- ex_bp_error  in  1  branch-mispredict flush
- exc_flush_all  in  1  exception flush
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  line address, {pc[ADDR_W-1:4],4'b0}
- mem_gnt  in  1  request granted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  4*INSN_W  line data, slot0 in LSBs
- icache_id_valid  out  1  output group valid
- icache_id_pc  out  ADDR_W  request PC of the group
- icache_id_insn  out  4*INSN_W  line words
- icache_id_mask  out  4  valid slots
- icache_id_delot_en  out  1  delay-slot flag passthrough
- id_allin  in  1  decode ready

Behaviour:
- Definitions:
  - flush = ex_bp_error | exc_flush_all.
  - accept = if_valid_ns & !if_rw & icache_allin & !flush.
  - A request presented in a flush cycle is never accepted.
- FSM states: IDLE, REQ, WAIT, OUT. Plus a 1-bit `kill` register and a request register {pc, delot}.
- Reset: state=IDLE, kill=0, mem_req=0, mem_addr=0, icache_id_valid=0, icache_id_pc=0, icache_id_insn=0, icache_id_mask=0, icache_id_delot_en=0.
- icache_allin (combinational) = (state==IDLE) | (state==OUT & id_allin).
- IDLE: on accept, latch the request, then go to REQ.
- REQ:
  - mem_req=1; mem_addr holds the line address.
  - mem_req stays asserted until mem_gnt, even across a flush.
  - On mem_gnt, go to WAIT.
  - A flush in REQ sets kill.
- WAIT:
  - A flush sets kill.
  - On mem_rvalid with kill=0 (and no flush that cycle): capture mem_rdata and go to OUT.
  - On mem_rvalid with kill=1 or flush: discard the data, clear kill, go to IDLE.
- OUT:
  - icache_id_valid=1; outputs are held stable until handshake.
  - If flush: valid=0, go to IDLE (flush wins over id_allin).
  - Else if id_allin and accept: latch the new request, go to REQ (back-to-back).
  - Else if id_allin: go to IDLE.
- Mask from pc[3:2]: 00→1111, 01→1110, 10→1100, 11→1000. This matches the fetch stage's +16/+12/+8/+4 next-PC step.
- If delot=1, the mask is one-hot at slot pc[3:2].
- Minimum latency with mem_gnt and mem_rvalid each arriving the cycle after they are awaited:
  - accept T, mem_req visible T+1, gnt T+1, rvalid T+2, icache_id_valid T+3.
- Only one outstanding memory transaction at a time.
- mem_rvalid outside WAIT is ignored.
- Asynchronous reset mid-transaction returns to IDLE immediately. The memory side is reset by the same rst_.

Optional Feature:
- Macro ICACHE_LINEBUF_EN.
- With the macro defined:
  - A one-entry line buffer holds {valid, tag=pc[ADDR_W-1:4], data}, filled on every non-killed mem_rvalid.
  - On an accepted request with buffer valid and matching tag, skip REQ/WAIT: the group is presented in OUT on the next cycle (latency 1), with no mem_req.
  - The buffer is invalidated only by reset; flush does not invalidate it.
- Without the macro: every request goes to memory, and no buffer storage is built.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, OUT=2'd3;
  - LINE_OFFSET_W=4;
  - the slot-mask constant table;
  - the fetch-group struct {pc, delot}.
- One natural sub-module: icache_linebuf (tag compare + data store), instantiated only under ICACHE_LINEBUF_EN.

Test Plan:
- Basic fetch:
  - Stimulus: pc=0xBFC00000, gnt at T+1, rvalid at T+2 with data 0x44444444_33333333_22222222_11111111, id_allin=1.
  - Required response: valid at T+3, mask=1111, insn equals the data, pc=0xBFC00000.
- Offset and delay slot:
  - pc=0x...08 → mask=1100.
  - pc=0x...0C → mask=1000.
  - pc=0x...04 with delot=1 → mask=0010 and icache_id_delot_en=1.
- Backpressure:
  - Stimulus: id_allin=0 for 5 cycles in OUT.
  - Required response: outputs stable, icache_allin=0. When id_allin rises with a new request, that request is accepted in the same cycle and mem_req=1 the next cycle.
- Flush while waiting:
  - Stimulus: ex_bp_error pulse in WAIT, rvalid arrives 3 cycles later.
  - Required response: data discarded, icache_id_valid stays 0, FSM returns to IDLE, a new request is accepted next.
- Flush in REQ and simultaneous request:
  - Stimulus: exc_flush_all in REQ before gnt; separately, a flush coinciding with if_valid_ns in IDLE.
  - Required response: mem_req held until gnt, then the response is dropped; the coinciding request is not accepted.
- Line buffer (ICACHE_LINEBUF_EN):
  - Stimulus: fetch 0x100 then 0x108.
  - Required response: the second request produces no mem_req, valid one cycle after accept with mask=1100. Without the macro, the second request issues mem_req.
